tritone_tpu_mmio_bridge: RTL and testbench
==========================================

Name: tritone_tpu_mmio_bridge

Overview:
Sequential bridge between the ternary CPU data-memory port and the TPU 32-bit register bus (cpu_sel/cpu_wen/cpu_ren/cpu_ready side of tpu_top).
- Decodes the 9-trit balanced-ternary address.
- Converts write data from balanced ternary to two's-complement int32 trit-serially.
- Issues the TPU access and waits for ready, with a timeout.
- Converts read data back to a 27-trit balanced-ternary word.
It replaces the bit-slicing glue between the CPU and the TPU.

Parameters:
TRIT_WIDTH, 27, data word width in trits
ADDR_TRITS, 9, address width in trits
DMEM_BASE, 32'h0200, linear offset added to the decoded CPU address
TPU_REG_BASE, 32'h1000, first TPU register linear address (inclusive)
TPU_MEM_BASE, 32'h2000, end of TPU register window (exclusive)
TIMEOUT_CYCLES, 64, ISSUE cycles without tpu_ready before abort

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
req_valid  in  1  CPU access request
req_we  in  1  1 = write, 0 = read
req_addr  in  ADDR_TRITS x trit_t  balanced-ternary address
req_wdata  in  TRIT_WIDTH x trit_t  write data
req_ready  out  1  high only in IDLE; request accepted on req_valid & req_ready
busy  out  1  not IDLE; drives CPU stall
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  TRIT_WIDTH x trit_t  read data, valid with rsp_valid
rsp_err  out  1  out-of-window, invalid trit code, or timeout
rsp_sat  out  1  write value clamped to int32
tpu_sel, tpu_wen, tpu_ren  out  1 each  TPU register bus strobes
tpu_addr  out  32  linear address minus TPU_REG_BASE
tpu_wdata  out  32  int32 write data
tpu_rdata  in  32  TPU read data
tpu_ready  in  1  TPU completion

Behaviour:
- Reset: state IDLE; req_ready=1; all other outputs 0; rsp_rdata all T_ZERO. rst asserted mid-operation aborts immediately: tpu_sel drops asynchronously and no response is generated.
- Accept (cycle 0): latch address as linear = DMEM_BASE + signed value of req_addr.
  - Out-of-window request (outside [TPU_REG_BASE, TPU_MEM_BASE)) or any invalid trit code in req_addr: RESP at cycle 1 with rsp_err=1 and no TPU strobe.
  - Write goes to CONV; read goes to ISSUE.
- CONV: exactly TRIT_WIDTH cycles (cycles 1..27), MSB first, Horner form acc = 3*acc + t.
  - Accumulator is signed 45 bits and cannot overflow.
  - Invalid trit code seen: sticky flag; at end go to RESP with rsp_err=1 and no TPU access.
  - Otherwise clamp: above 2^31-1 gives 0x7FFFFFFF, below -2^31 gives 0x80000000, either sets rsp_sat. Then go to ISSUE.
- ISSUE: tpu_sel=1 plus exactly one of tpu_wen/tpu_ren. tpu_addr and tpu_wdata stay stable while in ISSUE.
  - tpu_ready in the same cycle completes the access. Strobes drop the next cycle.
  - Write completes to RESP. Read captures tpu_rdata and goes to RCONV.
  - Timeout counter starts at 0 on entry. If TIMEOUT_CYCLES ISSUE cycles pass without tpu_ready: strobes drop, RESP with rsp_err=1 and rsp_rdata zero.
- RCONV: TRIT_WIDTH cycles, LSB first. Let r = floored (v mod 3).
  - r=0: trit 0, v = v/3.
  - r=1: trit +1, v = (v-1)/3.
  - r=2: trit -1, v = (v+1)/3.
  - Any int32 fits in 27 trits; v is 0 after the last trit.
- RESP: rsp_valid=1 for one cycle; rsp_err and rsp_sat are valid in that cycle only, 0 otherwise. Next state IDLE.
- Latency with tpu_ready already high:
  - write: rsp_valid at cycle 29;
  - read: ISSUE at cycle 1, rsp_valid at cycle 29;
  - out-of-window: rsp_valid at cycle 1.
- Back-to-back: the first new request is accepted in the cycle after RESP.
- There is no response backpressure; the CPU holds off further requests while busy.

Decomposition:
- Additions to ternary_pkg:
  - trit code constants (existing);
  - function trit_value returning -1/0/+1 plus a valid flag;
  - SoC address-map constants TPU_REG_BASE, TPU_MEM_BASE, DMEM_BASE;
  - typedef tword_t for TRIT_WIDTH x trit_t.
- One sub-module, bt_serial_conv: shared shift/accumulate datapath for both directions. It takes a mode input, start/done handshakes and a cycle counter. The top level keeps the FSM, timeout counter and TPU bus.

Test Plan:
- Write, req_addr = +3600 (linear 0x1010), req_wdata = +5 (trit0=-1, trit1=-1, trit2=+1), tpu_ready=1 -> cycle 28: tpu_sel=1, tpu_wen=1, tpu_addr=0x10, tpu_wdata=0x00000005; cycle 29: rsp_valid=1, rsp_err=0.
- Read, req_addr = +3584 (tpu_addr 0x0), tpu_rdata = 0xFFFFFFFE -> rsp_rdata trit0=+1, trit1=-1, others 0; rsp_valid at cycle 29.
- Write with all 27 trits +1 -> tpu_wdata = 0x7FFFFFFF, rsp_sat=1; all trits -1 -> 0x80000000, rsp_sat=1.
- Read with tpu_ready held 0 -> tpu_sel high for exactly 64 cycles, then rsp_valid with rsp_err=1 and rsp_rdata zero.
- req_addr = 0 (linear 0x200) -> no tpu_sel ever, rsp_valid at cycle 1 with rsp_err=1.
- rst pulsed at CONV cycle 10 -> all outputs 0 immediately, no rsp_valid, req_ready=1 after release; a following write completes normally.

Source files
------------

// File: rtl/tritone_tpu_mmio_bridge_pkg.sv
// Shared ternary types, trit codes, SoC address map and the trit decode helper.
// Latency: n/a (types, constants and a pure function).
// Backpressure: n/a.
package tritone_tpu_mmio_bridge_pkg;

   localparam int TRIT_WIDTH     = 27;
   localparam int ADDR_TRITS     = 9;
   localparam int ACC_W          = 45;
   localparam int DMEM_BASE      = 32'h0200;
   localparam int TPU_REG_BASE   = 32'h1000;
   localparam int TPU_MEM_BASE   = 32'h2000;
   localparam int TIMEOUT_CYCLES = 64;

   // Two-bit trit code; 2'b11 is the one invalid encoding.
   typedef logic [1:0] trit_t;
   localparam trit_t T_ZERO = 2'b00;
   localparam trit_t T_POS  = 2'b01;
   localparam trit_t T_NEG  = 2'b10;

   typedef trit_t [TRIT_WIDTH-1:0] tword_t;
   typedef trit_t [ADDR_TRITS-1:0] taddr_t;

   typedef struct packed {
      logic signed [1:0] val;
      logic              ok;
   } tval_t;

   typedef enum logic [2:0] {S_IDLE, S_CONV, S_ISSUE, S_RCONV, S_RESP} state_t;
   typedef enum logic {M_T2B, M_B2T} conv_mode_t;

   // Numeric value of one trit; invalid code decodes as 0 with ok cleared.
   function automatic tval_t trit_value(input trit_t t);
      tval_t r;
      r.ok = 1'b1;
      case (t)
         T_POS:   r.val = 2'sd1;
         T_NEG:   r.val = -2'sd1;
         T_ZERO:  r.val = 2'sd0;
         default: begin
            r.val = 2'sd0;
            r.ok  = 1'b0;
         end
      endcase
      return r;
   endfunction

endpackage

// File: rtl/tritone_tpu_mmio_bridge_bt_serial_conv.sv
// Trit-serial balanced-ternary <-> binary converter shared by both directions.
// Latency: TRIT_WIDTH cycles after start; done is high in the last working cycle.
// Backpressure: none; start is only issued by the FSM when the converter is idle.
module tritone_tpu_mmio_bridge_bt_serial_conv
   import tritone_tpu_mmio_bridge_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  conv_mode_t              mode,
   input  tword_t                  load_word,
   input  logic [31:0]             load_int,
   output logic                    done,
   output logic                    invalid,
   output logic signed [ACC_W-1:0] acc,
   output tword_t                  word
);

   localparam logic signed [ACC_W-1:0] THREE = ACC_W'(3);

   logic                    active_q, active_d;
   conv_mode_t              mode_q, mode_d;
   logic [4:0]              cnt_q, cnt_d;
   logic signed [ACC_W-1:0] acc_q, acc_d;
   tword_t                  shift_q, shift_d;
   logic                    inv_q, inv_d;

   tval_t                   msb_v;
   logic signed [ACC_W-1:0] msb_ext, rem, out_ext;
   trit_t                   out_t;

   assign done    = active_q && (cnt_q == 5'(TRIT_WIDTH-1));
   assign invalid = inv_q | (active_q && (mode_q == M_T2B) && !msb_v.ok);
   assign acc     = acc_q;
   assign word    = shift_q;

   // Per-cycle digit: MSB trit value (to binary) or floored residue digit (to ternary).
   always_comb begin
      msb_v   = trit_value(shift_q[TRIT_WIDTH-1]);
      msb_ext = ACC_W'(msb_v.val);
      rem     = acc_q % THREE;
      case (rem[2:0])
         3'b001, 3'b110: begin out_t = T_POS; out_ext = ACC_W'(1);  end
         3'b010, 3'b111: begin out_t = T_NEG; out_ext = -ACC_W'(1); end
         default:        begin out_t = T_ZERO; out_ext = '0;        end
      endcase
   end

   // Load on start, then one Horner step or one residue step per cycle.
   always_comb begin
      active_d = active_q;
      mode_d   = mode_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      shift_d  = shift_q;
      inv_d    = inv_q;
      if (start) begin
         active_d = 1'b1;
         mode_d   = mode;
         cnt_d    = '0;
         inv_d    = 1'b0;
         if (mode == M_T2B) begin
            acc_d   = '0;
            shift_d = load_word;
         end else begin
            acc_d   = ACC_W'($signed(load_int));
            shift_d = '0;
         end
      end else if (active_q) begin
         cnt_d = cnt_q + 5'd1;
         if (done) active_d = 1'b0;
         if (mode_q == M_T2B) begin
            acc_d   = acc_q * THREE + msb_ext;
            shift_d = {shift_q[TRIT_WIDTH-2:0], T_ZERO};
            inv_d   = inv_q | ~msb_v.ok;
         end else begin
            acc_d   = (acc_q - out_ext) / THREE;
            shift_d = {out_t, shift_q[TRIT_WIDTH-1:1]};
         end
      end
   end

   // Converter state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         active_q <= 1'b0;
         mode_q   <= M_T2B;
         cnt_q    <= '0;
         acc_q    <= '0;
         shift_q  <= '0;
         inv_q    <= 1'b0;
      end else begin
         active_q <= active_d;
         mode_q   <= mode_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         shift_q  <= shift_d;
         inv_q    <= inv_d;
      end
   end

endmodule

// File: rtl/tritone_tpu_mmio_bridge.sv
// Ternary CPU data port to TPU 32-bit register bus bridge with address decode and timeout.
// Latency: 29 cycles accept->rsp for reads and writes with ready high; 1 cycle for decode errors.
// Backpressure: req_ready only in IDLE; waits on tpu_ready up to TIMEOUT_CYCLES; no rsp stall.
module tritone_tpu_mmio_bridge
   import tritone_tpu_mmio_bridge_pkg::*;
#(
   parameter int DMEM_BASE_P      = DMEM_BASE,
   parameter int TPU_REG_BASE_P   = TPU_REG_BASE,
   parameter int TPU_MEM_BASE_P   = TPU_MEM_BASE,
   parameter int TIMEOUT_CYCLES_P = TIMEOUT_CYCLES
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic        req_we,
   input  taddr_t      req_addr,
   input  tword_t      req_wdata,
   output logic        req_ready,
   output logic        busy,
   output logic        rsp_valid,
   output tword_t      rsp_rdata,
   output logic        rsp_err,
   output logic        rsp_sat,
   output logic        tpu_sel,
   output logic        tpu_wen,
   output logic        tpu_ren,
   output logic [31:0] tpu_addr,
   output logic [31:0] tpu_wdata,
   input  logic [31:0] tpu_rdata,
   input  logic        tpu_ready
);

   state_t      state_q, state_d;
   logic        we_q, we_d;
   logic        err_q, err_d;
   logic [31:0] addr_q, addr_d;
   logic [15:0] tmo_q, tmo_d;

   logic signed [31:0] lin, pos;
   logic               addr_ok, in_win;
   tval_t              atv;

   logic                    conv_start, conv_done, conv_invalid;
   conv_mode_t              conv_mode;
   logic signed [ACC_W-1:0] conv_acc;
   tword_t                  conv_word;
   logic                    sat_hi, sat_lo;
   logic [31:0]             wdata_clamped;

   tritone_tpu_mmio_bridge_bt_serial_conv u_conv (
      .clk       (clk),
      .rst       (rst),
      .start     (conv_start),
      .mode      (conv_mode),
      .load_word (req_wdata),
      .load_int  (tpu_rdata),
      .done      (conv_done),
      .invalid   (conv_invalid),
      .acc       (conv_acc),
      .word      (conv_word)
   );

   // Decode the balanced-ternary address into the linear SoC map and window-check it.
   always_comb begin
      pos     = '0;
      addr_ok = 1'b1;
      for (int i = ADDR_TRITS-1; i >= 0; i--) begin
         atv     = trit_value(req_addr[i]);
         pos     = pos * 3 + 32'(atv.val);
         addr_ok = addr_ok & atv.ok;
      end
      lin    = DMEM_BASE_P + pos;
      in_win = addr_ok && (lin >= TPU_REG_BASE_P) && (lin < TPU_MEM_BASE_P);
   end

   // Saturate the 45-bit converted write value into int32.
   always_comb begin
      sat_hi = ~conv_acc[ACC_W-1] & (|conv_acc[ACC_W-2:31]);
      sat_lo =  conv_acc[ACC_W-1] & ~(&conv_acc[ACC_W-2:31]);
      if (sat_hi)      wdata_clamped = 32'h7FFF_FFFF;
      else if (sat_lo) wdata_clamped = 32'h8000_0000;
      else             wdata_clamped = conv_acc[31:0];
   end

   // State and transaction context registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
         addr_q  <= '0;
         tmo_q   <= '0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         err_q   <= err_d;
         addr_q  <= addr_d;
         tmo_q   <= tmo_d;
      end
   end

   // Next-state logic, converter kick-off and timeout counting.
   always_comb begin
      state_d    = state_q;
      we_d       = we_q;
      err_d      = err_q;
      addr_d     = addr_q;
      tmo_d      = tmo_q;
      conv_start = 1'b0;
      conv_mode  = M_T2B;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               we_d   = req_we;
               err_d  = ~in_win;
               addr_d = 32'(lin - TPU_REG_BASE_P);
               tmo_d  = '0;
               if (!in_win) begin
                  state_d = S_RESP;
               end else if (req_we) begin
                  state_d    = S_CONV;
                  conv_start = 1'b1;
               end else begin
                  state_d = S_ISSUE;
               end
            end
         end
         S_CONV: begin
            if (conv_done) begin
               if (conv_invalid) begin
                  err_d   = 1'b1;
                  state_d = S_RESP;
               end else begin
                  state_d = S_ISSUE;
               end
            end
         end
         S_ISSUE: begin
            if (tpu_ready) begin
               if (we_q) begin
                  state_d = S_RESP;
               end else begin
                  state_d    = S_RCONV;
                  conv_start = 1'b1;
                  conv_mode  = M_B2T;
               end
            end else if (tmo_q == 16'(TIMEOUT_CYCLES_P-1)) begin
               err_d   = 1'b1;
               state_d = S_RESP;
            end else begin
               tmo_d = tmo_q + 16'd1;
            end
         end
         S_RCONV: if (conv_done) state_d = S_RESP;
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs decoded from state so reset clears them asynchronously.
   always_comb begin
      req_ready = (state_q == S_IDLE);
      busy      = (state_q != S_IDLE);
      tpu_sel   = (state_q == S_ISSUE);
      tpu_wen   = (state_q == S_ISSUE) &  we_q;
      tpu_ren   = (state_q == S_ISSUE) & ~we_q;
      tpu_addr  = (state_q == S_ISSUE) ? addr_q : '0;
      tpu_wdata = ((state_q == S_ISSUE) && we_q) ? wdata_clamped : '0;
      rsp_valid = (state_q == S_RESP);
      rsp_err   = (state_q == S_RESP) & err_q;
      rsp_sat   = (state_q == S_RESP) & we_q & ~err_q & (sat_hi | sat_lo);
      rsp_rdata = ((state_q == S_RESP) && !we_q && !err_q) ? conv_word : '0;
   end

endmodule

// File: tb/tb_tritone_tpu_mmio_bridge.sv
// Directed table-driven bench for the ternary CPU to TPU register bus bridge.
// Each vector records per-cycle bus activity and the response, then compares to hand values.
// Reset-abort sequences are exercised separately after the table.
module tb_tritone_tpu_mmio_bridge;
   import tritone_tpu_mmio_bridge_pkg::*;

   localparam longint OFF27 = 64'sd3812798742493;  // (3^27-1)/2: all +1 trits
   localparam int     NV    = 18;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_we;
   taddr_t      req_addr;
   tword_t      req_wdata;
   logic        req_ready, busy, rsp_valid, rsp_err, rsp_sat;
   tword_t      rsp_rdata;
   logic        tpu_sel, tpu_wen, tpu_ren, tpu_ready;
   logic [31:0] tpu_addr, tpu_wdata, tpu_rdata;

   always #5 clk = ~clk;

   tritone_tpu_mmio_bridge dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_ready(req_ready), .busy(busy),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_sat(rsp_sat),
      .tpu_sel(tpu_sel), .tpu_wen(tpu_wen), .tpu_ren(tpu_ren),
      .tpu_addr(tpu_addr), .tpu_wdata(tpu_wdata), .tpu_rdata(tpu_rdata), .tpu_ready(tpu_ready)
   );

   typedef struct {
      logic        we;
      int          addr;
      longint      wdata;
      int          bad_w;
      int          bad_a;
      logic [31:0] rdata;
      int          dly;
      int          exp_cyc;
      logic        exp_err;
      logic        exp_sat;
      int          exp_nsel;
      int          exp_first;
      logic [31:0] exp_addr;
      logic [31:0] exp_wdata;
      longint      exp_rval;
   } vec_t;

   vec_t vt [NV];
   int   n_chk  = 0;
   int   n_pass = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Balanced ternary via offset unsigned base-3 digits (digit-1 per position).
   function automatic tword_t enc(input longint v);
      tword_t w;
      longint u;
      u = v + OFF27;
      for (int i = 0; i < TRIT_WIDTH; i++) begin
         case (u % 3)
            0:       w[i] = T_NEG;
            1:       w[i] = T_ZERO;
            default: w[i] = T_POS;
         endcase
         u = u / 3;
      end
      return w;
   endfunction

   task automatic run_vec(input int i);
      vec_t        v;
      tword_t      w, ta;
      taddr_t      a;
      int          nsel, first, cyc;
      logic        unstable, c_wen, c_ren, g_err, g_sat;
      logic [31:0] c_addr, c_wd;
      tword_t      g_rd;
      v  = vt[i];
      w  = enc(v.wdata);
      if (v.bad_w >= 0) w[v.bad_w] = 2'b11;
      ta = enc(longint'(v.addr));
      a  = ta[ADDR_TRITS-1:0];
      if (v.bad_a >= 0) a[v.bad_a] = 2'b11;
      nsel = 0; first = -1; cyc = -1; unstable = 1'b0;
      c_wen = 1'b0; c_ren = 1'b0; c_addr = '0; c_wd = '0;
      g_err = 1'b0; g_sat = 1'b0; g_rd = '0;

      @(posedge clk); #1;
      req_valid = 1'b1; req_we = v.we; req_addr = a; req_wdata = w;
      tpu_rdata = v.rdata; tpu_ready = (v.dly == 0);
      for (int k = 0; k < 120 && cyc < 0; k++) begin
         @(negedge clk);
         if (k == 0) begin
            chk($sformatf("v%0d_req_ready", i), req_ready, 1'b1);
            chk($sformatf("v%0d_idle_rsp", i), rsp_valid, 1'b0);
         end
         if (tpu_sel) begin
            if (first < 0) begin
               first = k; c_wen = tpu_wen; c_ren = tpu_ren; c_addr = tpu_addr; c_wd = tpu_wdata;
            end else if (tpu_addr !== c_addr || tpu_wdata !== c_wd) begin
               unstable = 1'b1;
            end
            nsel++;
         end
         if (rsp_valid) begin
            cyc = k; g_err = rsp_err; g_sat = rsp_sat; g_rd = rsp_rdata;
         end else begin
            @(posedge clk); #1;
            req_valid = 1'b0;
            tpu_ready = (nsel >= v.dly);
         end
      end
      req_valid = 1'b0;
      chk($sformatf("v%0d_rsp_cycle", i), 64'(cyc), 64'(v.exp_cyc));
      chk($sformatf("v%0d_rsp_err", i), g_err, v.exp_err);
      chk($sformatf("v%0d_rsp_sat", i), g_sat, v.exp_sat);
      chk($sformatf("v%0d_sel_cycles", i), 64'(nsel), 64'(v.exp_nsel));
      if (v.exp_nsel > 0) begin
         chk($sformatf("v%0d_first_sel", i), 64'(first), 64'(v.exp_first));
         chk($sformatf("v%0d_wen", i), c_wen, v.we);
         chk($sformatf("v%0d_ren", i), c_ren, !v.we);
         chk($sformatf("v%0d_tpu_addr", i), c_addr, v.exp_addr);
         chk($sformatf("v%0d_stable", i), unstable, 1'b0);
         if (v.we) chk($sformatf("v%0d_tpu_wdata", i), c_wd, v.exp_wdata);
      end
      if (!v.we) chk($sformatf("v%0d_rsp_rdata", i), g_rd, enc(v.exp_rval));
   endtask

   initial begin
      int nrsp, nsel2;
      //           we  addr   wdata             bw  ba  rdata          dly  cyc err sat nsel first addr      wdata          rval
      vt[0]  = '{1'b1, 3600, 64'sd5,           -1, -1, 32'h0,         0,   29, 0, 0, 1,  28, 32'h10,  32'h5,         64'sd0};
      vt[1]  = '{1'b0, 3584, 64'sd0,           -1, -1, 32'hFFFFFFFE,  0,   29, 0, 0, 1,  1,  32'h0,   32'h0,         -64'sd2};
      vt[2]  = '{1'b1, 3585, OFF27,            -1, -1, 32'h0,         0,   29, 0, 1, 1,  28, 32'h1,   32'h7FFFFFFF,  64'sd0};
      vt[3]  = '{1'b1, 3586, -OFF27,           -1, -1, 32'h0,         0,   29, 0, 1, 1,  28, 32'h2,   32'h80000000,  64'sd0};
      vt[4]  = '{1'b0, 3584, 64'sd0,           -1, -1, 32'h12345678,  1000,65, 1, 0, 64, 1,  32'h0,   32'h0,         64'sd0};
      vt[5]  = '{1'b1, 0,    64'sd5,           -1, -1, 32'h0,         0,   1,  1, 0, 0,  0,  32'h0,   32'h0,         64'sd0};
      vt[6]  = '{1'b0, 3589, 64'sd0,           -1, -1, 32'h7FFFFFFF,  0,   29, 0, 0, 1,  1,  32'h5,   32'h0,         64'sd2147483647};
      vt[7]  = '{1'b0, 7679, 64'sd0,           -1, -1, 32'h80000000,  0,   29, 0, 0, 1,  1,  32'hFFF, 32'h0,         -64'sd2147483648};
      vt[8]  = '{1'b1, 7680, 64'sd5,           -1, -1, 32'h0,         0,   1,  1, 0, 0,  0,  32'h0,   32'h0,         64'sd0};
      vt[9]  = '{1'b0, 3583, 64'sd0,           -1, -1, 32'h0,         0,   1,  1, 0, 0,  0,  32'h0,   32'h0,         64'sd0};
      vt[10] = '{1'b1, 3600, 64'sd7,           3,  -1, 32'h0,         0,   28, 1, 0, 0,  0,  32'h0,   32'h0,         64'sd0};
      vt[11] = '{1'b0, 3600, 64'sd0,           -1, 4,  32'h0,         0,   1,  1, 0, 0,  0,  32'h0,   32'h0,         64'sd0};
      vt[12] = '{1'b1, -100, 64'sd5,           -1, -1, 32'h0,         0,   1,  1, 0, 0,  0,  32'h0,   32'h0,         64'sd0};
      vt[13] = '{1'b0, 4000, 64'sd0,           -1, -1, 32'h00012345,  3,   32, 0, 0, 4,  1,  32'h1A0, 32'h0,         64'sd74565};
      vt[14] = '{1'b1, 3600, -64'sd12345,      -1, -1, 32'h0,         2,   31, 0, 0, 3,  28, 32'h10,  32'hFFFFCFC7,  64'sd0};
      vt[15] = '{1'b1, 3600, 64'sd2147483647,  -1, -1, 32'h0,         0,   29, 0, 0, 1,  28, 32'h10,  32'h7FFFFFFF,  64'sd0};
      vt[16] = '{1'b1, 3600, -64'sd2147483649, -1, -1, 32'h0,         0,   29, 0, 1, 1,  28, 32'h10,  32'h80000000,  64'sd0};
      vt[17] = '{1'b1, 3600, 64'sd2147483648,  -1, -1, 32'h0,         0,   29, 0, 1, 1,  28, 32'h10,  32'h7FFFFFFF,  64'sd0};

      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
      tpu_rdata = '0; tpu_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_req_ready", req_ready, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_rsp_valid", rsp_valid, 1'b0);
      chk("rst_rsp_err", rsp_err, 1'b0);
      chk("rst_rsp_sat", rsp_sat, 1'b0);
      chk("rst_rsp_rdata", rsp_rdata, '0);
      chk("rst_tpu_strobes", {tpu_sel, tpu_wen, tpu_ren}, 3'b000);
      chk("rst_tpu_addr", tpu_addr, 32'h0);
      chk("rst_tpu_wdata", tpu_wdata, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;

      for (int i = 0; i < NV; i++) run_vec(i);

      // Reset in the middle of write conversion.
      @(posedge clk); #1;
      req_valid = 1'b1; req_we = 1'b1; req_addr = '0; req_wdata = enc(64'sd5);
      begin
         tword_t ta;
         ta = enc(64'sd3600);
         req_addr = ta[ADDR_TRITS-1:0];
      end
      tpu_ready = 1'b1;
      repeat (10) begin @(posedge clk); #1; req_valid = 1'b0; end
      #3;
      chk("conv_busy_before_rst", busy, 1'b1);
      rst = 1'b1;
      #1;
      chk("conv_rst_busy", busy, 1'b0);
      chk("conv_rst_req_ready", req_ready, 1'b1);
      chk("conv_rst_outputs", {tpu_sel, tpu_wen, tpu_ren, rsp_valid, rsp_err, rsp_sat}, 6'b0);
      @(posedge clk); #1;
      rst = 1'b0;
      nrsp = 0; nsel2 = 0;
      repeat (40) begin
         @(negedge clk);
         if (rsp_valid) nrsp++;
         if (tpu_sel) nsel2++;
      end
      chk("conv_rst_no_rsp", 64'(nrsp), 64'd0);
      chk("conv_rst_no_sel", 64'(nsel2), 64'd0);
      chk("conv_rst_ready_after", req_ready, 1'b1);
      run_vec(0);

      // Reset while a read is stalled in ISSUE: strobes must drop without a clock edge.
      @(posedge clk); #1;
      begin
         tword_t ta;
         ta = enc(64'sd3584);
         req_addr = ta[ADDR_TRITS-1:0];
      end
      req_valid = 1'b1; req_we = 1'b0; tpu_ready = 1'b0;
      repeat (5) begin @(posedge clk); #1; req_valid = 1'b0; end
      #3;
      chk("issue_sel_before_rst", {tpu_sel, tpu_ren}, 2'b11);
      rst = 1'b1;
      #1;
      chk("issue_rst_strobes", {tpu_sel, tpu_wen, tpu_ren}, 3'b000);
      chk("issue_rst_rsp", rsp_valid, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0;
      run_vec(1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
